mem_access_unit: RTL

Memory-stage load/store controller sitting directly downstream of the ALU. It takes the ALU result as the effective address and the Rt value as store data. It runs one aligned 64-bit bus transaction with a req/ack handshake and stalls the pipeline until the access completes. It returns lane-extracted, zero-extended load data for writeback and flags misaligned or errored accesses.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: one aligned 64-bit req/ack bus access per
// instruction, pipeline stall while busy, zero-extended load writeback, fault flagging.
module mem_access_unit #(
  parameter int unsigned BUS_AW = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic              mem_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [63:0]       bus_rdata
);

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_next;
  logic              accept, illegal;
  logic              bus_req_n, bus_we_n, wb_valid_n, mem_fault_n;
  logic [BUS_AW-1:0] bus_addr_n;
  logic [DW-1:0]     bus_wdata_n, wb_data_n;
  logic [SW-1:0]     bus_wstrb_n;
  logic              is_load, is_load_n;
  logic [2:0]        off_q, off_n;
  logic [1:0]        size_q, size_n;

  // Data mask covering the low 8*2^sz bits.
  function automatic logic [DW-1:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [SW-1:0] strb_base(input logic [1:0] sz);
    case (sz)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lo);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lo[0];
      2'd2:    misaligned = |lo[1:0];
      default: misaligned = |lo;
    endcase
  endfunction

  assign accept  = (state == IDLE) && ex_valid && (mem_read || mem_write);
  assign illegal = misaligned(size, addr[2:0]) || (mem_read && mem_write);
  assign stall   = accept || (state == REQ);

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_next  = state;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    bus_wstrb_n = bus_wstrb;
    wb_data_n   = wb_data;
    wb_valid_n  = 1'b0;
    mem_fault_n = 1'b0;
    is_load_n   = is_load;
    off_n       = off_q;
    size_n      = size_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_next  = DONE;
            mem_fault_n = 1'b1;
          end else begin
            state_next  = REQ;
            bus_req_n   = 1'b1;
            bus_we_n    = mem_write;
            bus_addr_n  = BUS_AW'({addr[63:3], 3'b000});
            bus_wdata_n = mem_write ? DW'((wdata & lane_mask(size)) << {addr[2:0], 3'b000})
                                    : '0;
            bus_wstrb_n = mem_write ? SW'(strb_base(size) << addr[2:0]) : '0;
            is_load_n   = mem_read;
            off_n       = addr[2:0];
            size_n      = size;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_next  = DONE;
          bus_req_n   = 1'b0;
          mem_fault_n = bus_err;
          if (is_load && !bus_err) begin
            wb_valid_n = 1'b1;
            wb_data_n  = (bus_rdata >> {off_q, 3'b000}) & lane_mask(size_q);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      wb_data   <= '0;
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      is_load   <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
    end else begin
      state     <= state_next;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      bus_wstrb <= bus_wstrb_n;
      wb_data   <= wb_data_n;
      wb_valid  <= wb_valid_n;
      mem_fault <= mem_fault_n;
      is_load   <= is_load_n;
      off_q     <= off_n;
      size_q    <= size_n;
    end
  end

endmodule
